// File: rtl/rng_arbiter_if.sv
// rtl/rng_arbiter_if.sv - requester and generator signal bundle for rng_arbiter
interface rng_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4
);
    logic [NUM_REQ-1:0] i_req;
    logic [NUM_REQ-1:0] o_ack;
    logic [DATA_W-1:0]  o_data;
    logic               o_busy;
    logic               o_gen_start;
    logic               i_gen_valid;
    logic [DATA_W-1:0]  i_gen_data;
    logic               o_timeout;

    // arbiter side
    modport slave (
        input  i_req,
        input  i_gen_valid,
        input  i_gen_data,
        output o_ack,
        output o_data,
        output o_busy,
        output o_gen_start,
        output o_timeout
    );

    // consumer/generator side
    modport master (
        output i_req,
        output i_gen_valid,
        output i_gen_data,
        input  o_ack,
        input  o_data,
        input  o_busy,
        input  o_gen_start,
        input  o_timeout
    );
endinterface

// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - round-robin sharing of one RNG; build option RNG_ARB_TIMEOUT_EN adds a WAIT timeout
module rng_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    rng_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               gen_start_q, gen_start_d;
    logic               found;
    logic [IDX_W-1:0]   cand;
`ifdef RNG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
`endif

    // Next-state, grant search and registered-output decode
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        data_d      = data_q;
        found       = 1'b0;
        cand        = '0;
`ifdef RNG_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // first set request at or above ptr, wrapping to 0
                for (int i = 0; i < NUM_REQ; i++) begin
                    cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
                    if (!found && bus.i_req[cand]) begin
                        found  = 1'b1;
                        gidx_d = cand;
                    end
                end
                if (found) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef RNG_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (bus.i_gen_valid) begin
                    data_d  = bus.i_gen_data;
                    state_d = S_ACK;
                end
`ifdef RNG_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    data_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = S_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_ACK: begin
                ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        gen_start_d = (state_d == S_START);
        ack_d       = (state_d == S_ACK) ? (NUM_REQ'(1) << gidx_d) : '0;
    end

    // State and output registers, all cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            data_q      <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            gen_start_q <= 1'b0;
`ifdef RNG_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            gen_start_q <= gen_start_d;
`ifdef RNG_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bus.o_ack       = ack_q;
    assign bus.o_data      = data_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_gen_start = gen_start_q;
`ifdef RNG_ARB_TIMEOUT_EN
    assign bus.o_timeout   = timeout_q;
`else
    // always 0; TIMEOUT_CYC is referenced only to keep it meaningful in this build
    assign bus.o_timeout   = 1'b0 & (TIMEOUT_CYC < 1);
`endif
endmodule

// File: tb/tb_rng_arbiter.sv
// tb/tb_rng_arbiter.sv - randomized self-checking bench for rng_arbiter
module tb_rng_arbiter;
    localparam int NR = 4;
    localparam int DW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rng_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    rng_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // reference state: round-robin pointer and last value returned
    int            m_ptr  = 0;
    logic [DW-1:0] m_data = '0;

    function automatic int model_pick(input logic [NR-1:0] r, input int p);
        for (int i = 0; i < NR; i++) begin
            if (r[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        bus.i_req = '0;
        bus.i_gen_valid = 1'b0;
        step;
        rst = 1'b0;
        m_ptr  = 0;
        m_data = '0;
    endtask

    // One full transaction starting in IDLE; checks every cycle against the model.
    task automatic do_txn(input logic [NR-1:0] req, input int lat, input logic [DW-1:0] val,
                          input bit spur, input bit drop, output logic [NR-1:0] got_ack);
        int g;
        logic [NR-1:0] one;
        logic [NR-1:0] exp_ack;
        one = 1;
        g = model_pick(req, m_ptr);
        exp_ack = one << g;
        bus.i_req = req;
        bus.i_gen_valid = spur;
        bus.i_gen_data = ~val;
        step;
        n_total++; if (bus.o_gen_start !== 1'b1) $display("FAIL start_pulse: got %b want 1", bus.o_gen_start); else n_pass++;
        n_total++; if (bus.o_busy !== 1'b1) $display("FAIL start_busy: got %b want 1", bus.o_busy); else n_pass++;
        n_total++; if (bus.o_ack !== '0) $display("FAIL start_ack: got %b want 0", bus.o_ack); else n_pass++;
        n_total++; if (bus.o_data !== m_data) $display("FAIL start_data_hold: got %h want %h", bus.o_data, m_data); else n_pass++;
        if (drop) bus.i_req = '0;
        step;
        for (int k = 0; k <= lat; k++) begin
            n_total++; if (bus.o_gen_start !== 1'b0) $display("FAIL wait_start: got %b want 0", bus.o_gen_start); else n_pass++;
            n_total++; if (bus.o_busy !== 1'b1) $display("FAIL wait_busy: got %b want 1", bus.o_busy); else n_pass++;
            n_total++; if (bus.o_ack !== '0) $display("FAIL wait_ack: got %b want 0", bus.o_ack); else n_pass++;
            n_total++; if (bus.o_data !== m_data) $display("FAIL wait_data_hold: got %h want %h", bus.o_data, m_data); else n_pass++;
            bus.i_gen_valid = (k == lat);
            bus.i_gen_data = (k == lat) ? val : ~val;
            step;
        end
        got_ack = bus.o_ack;
        n_total++; if (bus.o_ack !== exp_ack) $display("FAIL ack_grant: got %b want %b", bus.o_ack, exp_ack); else n_pass++;
        n_total++; if (bus.o_data !== val) $display("FAIL ack_data: got %h want %h", bus.o_data, val); else n_pass++;
        n_total++; if (bus.o_busy !== 1'b1) $display("FAIL ack_busy: got %b want 1", bus.o_busy); else n_pass++;
        n_total++; if (bus.o_timeout !== 1'b0) $display("FAIL ack_timeout: got %b want 0", bus.o_timeout); else n_pass++;
        bus.i_gen_valid = 1'b0;
        m_ptr  = (g + 1) % NR;
        m_data = val;
        step;
        n_total++; if (bus.o_ack !== '0) $display("FAIL post_ack: got %b want 0", bus.o_ack); else n_pass++;
        n_total++; if (bus.o_busy !== 1'b0) $display("FAIL post_busy: got %b want 0", bus.o_busy); else n_pass++;
        n_total++; if (bus.o_data !== val) $display("FAIL post_data_hold: got %h want %h", bus.o_data, val); else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.i_req = '1;
        bus.i_gen_valid = 1'b1;
        bus.i_gen_data = 4'hF;
        step;
        step;
        n_total++; if (bus.o_ack !== '0) $display("FAIL reset_ack: got %b want 0", bus.o_ack); else n_pass++;
        n_total++; if (bus.o_data !== '0) $display("FAIL reset_data: got %h want 0", bus.o_data); else n_pass++;
        n_total++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.o_busy); else n_pass++;
        n_total++; if (bus.o_gen_start !== 1'b0) $display("FAIL reset_start: got %b want 0", bus.o_gen_start); else n_pass++;
        n_total++; if (bus.o_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.o_timeout); else n_pass++;
        bus.i_req = '0;
        bus.i_gen_valid = 1'b0;
        rst = 1'b0;
        step;
        n_total++; if (bus.o_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.o_busy); else n_pass++;
    endtask

    task automatic test_single;
        logic [NR-1:0] got;
        do_txn(4'b0001, 0, 4'hA, 1'b0, 1'b1, got);
        n_total++; if (got !== 4'b0001) $display("FAIL single_ack: got %b want 0001", got); else n_pass++;
    endtask

    task automatic test_fairness;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [NR-1:0] got;
        logic [NR-1:0] one;
        one = 1;
        apply_reset;
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 0, 4'($urandom), 1'b0, 1'b0, got);
            n_total++; if (got !== (one << order[i])) $display("FAIL fair_order[%0d]: got %b want %b", i, got, one << order[i]); else n_pass++;
        end
        bus.i_req = '0;
    endtask

    task automatic test_wrap;
        logic [NR-1:0] got;
        apply_reset;
        do_txn(4'b0010, 0, 4'h3, 1'b0, 1'b1, got);
        do_txn(4'b0011, 1, 4'hC, 1'b0, 1'b1, got);
        n_total++; if (got !== 4'b0001) $display("FAIL wrap_grant: got %b want 0001", got); else n_pass++;
    endtask

    task automatic test_spurious;
        logic [NR-1:0] got;
        do_txn(4'b0100, 1, 4'h6, 1'b1, 1'b1, got);
        n_total++; if (bus.o_data !== 4'h6) $display("FAIL spurious_data: got %h want 6", bus.o_data); else n_pass++;
    endtask

    task automatic test_reset_mid_wait;
        logic [NR-1:0] got;
        bus.i_req = 4'b0100;
        step;
        step;
        n_total++; if (bus.o_busy !== 1'b1) $display("FAIL midwait_busy: got %b want 1", bus.o_busy); else n_pass++;
        rst = 1'b1;
        step;
        rst = 1'b0;
        bus.i_req = '0;
        bus.i_gen_valid = 1'b1;
        bus.i_gen_data = 4'h5;
        m_ptr  = 0;
        m_data = '0;
        n_total++; if (bus.o_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.o_busy); else n_pass++;
        n_total++; if (bus.o_data !== '0) $display("FAIL midrst_data: got %h want 0", bus.o_data); else n_pass++;
        step;
        n_total++; if (bus.o_ack !== '0) $display("FAIL late_valid_ack: got %b want 0", bus.o_ack); else n_pass++;
        n_total++; if (bus.o_busy !== 1'b0) $display("FAIL late_valid_busy: got %b want 0", bus.o_busy); else n_pass++;
        n_total++; if (bus.o_gen_start !== 1'b0) $display("FAIL late_valid_start: got %b want 0", bus.o_gen_start); else n_pass++;
        bus.i_gen_valid = 1'b0;
        do_txn(4'b1001, 0, 4'h9, 1'b0, 1'b1, got);
        n_total++; if (got !== 4'b0001) $display("FAIL post_reset_grant: got %b want 0001", got); else n_pass++;
    endtask

    task automatic test_random;
        logic [NR-1:0] got;
        logic [NR-1:0] r;
        for (int t = 0; t < 30; t++) begin
            r = NR'($urandom_range(1, 15));
            do_txn(r, int'($urandom_range(0, 3)), DW'($urandom), 1'($urandom), 1'($urandom), got);
            if ($urandom_range(0, 2) == 0) begin
                bus.i_req = '0;
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    step;
                    n_total++; if (bus.o_busy !== 1'b0) $display("FAIL gap_busy: got %b want 0", bus.o_busy); else n_pass++;
                end
            end
        end
        bus.i_req = '0;
        step;
    endtask

    task automatic test_timeout;
        int g;
        logic [NR-1:0] one;
        one = 1;
        g = model_pick(4'b0001, m_ptr);
        bus.i_req = 4'b0001;
        bus.i_gen_valid = 1'b0;
        step;
        n_total++; if (bus.o_gen_start !== 1'b1) $display("FAIL to_start: got %b want 1", bus.o_gen_start); else n_pass++;
        bus.i_req = '0;
        step;
`ifdef RNG_ARB_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            n_total++; if (bus.o_ack !== '0 || bus.o_busy !== 1'b1) $display("FAIL to_wait[%0d]: ack %b busy %b want 0 1", k, bus.o_ack, bus.o_busy); else n_pass++;
            step;
        end
        n_total++; if (bus.o_ack !== (one << g)) $display("FAIL to_ack: got %b want %b", bus.o_ack, one << g); else n_pass++;
        n_total++; if (bus.o_data !== '0) $display("FAIL to_data: got %h want 0", bus.o_data); else n_pass++;
        n_total++; if (bus.o_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", bus.o_timeout); else n_pass++;
        m_ptr  = (g + 1) % NR;
        m_data = '0;
        step;
        n_total++; if (bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b0) $display("FAIL to_after: timeout %b busy %b want 0 0", bus.o_timeout, bus.o_busy); else n_pass++;
`else
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 1000; k++) begin
                if (bus.o_busy !== 1'b1 || bus.o_ack !== '0 || bus.o_timeout !== 1'b0) bad++;
                step;
            end
            n_total++; if (bad !== 0) $display("FAIL no_to_stuck: bad cycles %0d want 0 (grant %0d)", bad, g); else n_pass++;
            apply_reset;
            step;
            n_total++; if (bus.o_busy !== 1'b0) $display("FAIL no_to_recover: got %b want 0", bus.o_busy); else n_pass++;
        end
`endif
    endtask

    initial begin
        bus.i_req = '0;
        bus.i_gen_valid = 1'b0;
        bus.i_gen_data = '0;
        test_reset;
        test_single;
        test_fairness;
        test_wrap;
        test_spurious;
        test_reset_mid_wait;
        test_random;
        test_timeout;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
